// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared encodings for the page-table-walk memory arbiter: FSM states,
// requester identities and the SV32 PTE width.
package ptw_mem_arbiter_pkg;

  localparam int PTE_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/ptw_mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between the IFU (bit 0) and LSU
// (bit 1) walkers; a tie goes to whoever did not own the last access.
module rr_arbiter2
  import ptw_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_grant_valid,
  output logic       o_grant_owner
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_owner = OWNER_IFU;
    if (i_req == 2'b11) begin
      o_grant_owner = ~i_last_owner;
    end else if (i_req[OWNER_LSU]) begin
      o_grant_owner = OWNER_LSU;
    end
  end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one PTE read port between the IFU and LSU MMU walkers with a single
// outstanding access, round-robin arbitration, flush handling and a watchdog.
module ptw_mem_arbiter
  import ptw_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = PTE_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_i,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rvalid_o,
  input  logic              lsu_req_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES > 0);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic              r_owner;
  logic              r_last_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;
  logic [CNT_W-1:0]  r_wdog_cnt;
  logic              r_timeout;
  logic              w_grant_valid;
  logic              w_grant_owner;
  logic              w_take_data;
  logic              w_counting;

  rr_arbiter2 u_rr_arbiter2 (
    .i_req         ({lsu_req_i, ifu_req_i}),
    .i_last_owner  (r_last_owner),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!flush_i && w_grant_valid) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_ready_i)  w_state_next = flush_i ? ST_DRAIN : ST_WAIT;
        else if (flush_i) w_state_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_rvalid_i) w_state_next = flush_i ? ST_IDLE : ST_RESP;
        else if (flush_i) w_state_next = ST_DRAIN;
      end
      ST_RESP:  w_state_next = ST_IDLE;
      ST_DRAIN: begin
        if (mem_rvalid_i) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_take_data = (r_state == ST_WAIT) && mem_rvalid_i && !flush_i;
  assign w_counting  = WDOG_EN && ((r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                                   (r_state == ST_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWNER_IFU;
      r_last_owner <= OWNER_LSU;
      r_mem_addr   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && (w_state_next == ST_ISSUE)) begin
        r_owner    <= w_grant_owner;
        r_mem_addr <= (w_grant_owner == OWNER_LSU) ? lsu_addr_i : ifu_addr_i;
      end
      if (r_state == ST_RESP) r_last_owner <= r_owner;
    end
  end

  // Only the owner's data register is written; the other walker keeps its last PTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else if (w_take_data) begin
      if (r_owner == OWNER_LSU) r_lsu_rdata <= mem_rdata_i;
      else                      r_ifu_rdata <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_state_next == ST_IDLE) begin
        r_wdog_cnt <= '0;
      end else if (w_counting && (r_wdog_cnt != CNT_MAX)) begin
        r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
      end
      if (w_counting && (r_wdog_cnt == CNT_LAST)) r_timeout <= 1'b1;
    end
  end

  assign mem_req_o    = (r_state == ST_ISSUE);
  assign mem_addr_o   = r_mem_addr;
  assign busy_o       = (r_state != ST_IDLE);
  assign owner_o      = r_owner;
  assign timeout_o    = r_timeout;
  assign ifu_rdata_o  = r_ifu_rdata;
  assign lsu_rdata_o  = r_lsu_rdata;
  assign ifu_rvalid_o = (r_state == ST_RESP) && (r_owner == OWNER_IFU) && !flush_i;
  assign lsu_rvalid_o = (r_state == ST_RESP) && (r_owner == OWNER_LSU) && !flush_i;

endmodule

// File: doc/ptw_mem_arbiter.md
Name: ptw_mem_arbiter

Overview:
- Shares one page-table-walk memory read port between the IFU MMU walker and the LSU MMU walker.
- Each requester uses a level req/addr → rdata/rvalid interface, matching the mmu memory-walk interface.
- Sits between the two mmu instances and the memory/bus adapter.
- At most one access is outstanding. Arbitration is round-robin. Flush (sfence/satp write) drops in-flight responses.

Parameters:
- ADDR_W, 32, physical address width of PTE reads
- DATA_W, 32, PTE width (SV32)
- TIMEOUT_CYCLES, 1024, cycles in ISSUE/WAIT/DRAIN before the timeout flag sets; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_i  in  1  IFU walker read request, level, held until ifu_rvalid_o
- ifu_addr_i  in  ADDR_W  IFU PTE address, stable while ifu_req_i is high
- ifu_rdata_o  out  DATA_W  IFU PTE data, valid with ifu_rvalid_o
- ifu_rvalid_o  out  1  one-cycle IFU response pulse
- lsu_req_i  in  1  LSU walker read request, same rules as IFU
- lsu_addr_i  in  ADDR_W  LSU PTE address
- lsu_rdata_o  out  DATA_W  LSU PTE data
- lsu_rvalid_o  out  1  one-cycle LSU response pulse
- flush_i  in  1  MMU flush; abandons the current walk access
- mem_req_o  out  1  downstream read request (valid)
- mem_addr_o  out  ADDR_W  downstream address, registered
- mem_ready_i  in  1  downstream accepts the request this cycle
- mem_rdata_i  in  DATA_W  downstream read data
- mem_rvalid_i  in  1  downstream read data valid
- busy_o  out  1  state != IDLE
- owner_o  out  1  current/last grant: 0 = IFU, 1 = LSU
- timeout_o  out  1  sticky watchdog flag, cleared only by reset

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0; last_owner = 1 (LSU), so IFU wins the first tie; watchdog counter 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If flush_i is high, no grant is made.
  - Otherwise, only one requester high → grant it.
  - Both high → grant ~last_owner.
  - On a grant: latch addr into mem_addr_o, set owner_o → ISSUE.
- ISSUE:
  - mem_req_o = 1.
  - mem_ready_i & !flush_i → WAIT.
  - mem_ready_i & flush_i → DRAIN.
  - !mem_ready_i & flush_i → IDLE, request withdrawn (legal only while not accepted).
- WAIT:
  - mem_req_o = 0.
  - mem_rvalid_i & !flush_i → register rdata into the owner's rdata_o → RESP.
  - mem_rvalid_i & flush_i → IDLE, data dropped.
  - flush_i alone → DRAIN.
- RESP:
  - Owner's rvalid_o = 1 for exactly one cycle, unless flush_i is high this cycle (then it is suppressed).
  - last_owner ← owner → IDLE.
  - Latency: mem_rvalid_i at cycle t → rvalid_o at t+1.
- Requester contract: each walker drops or changes req the cycle after it sees rvalid. RESP guarantees IDLE never samples a stale req.
- DRAIN: wait for mem_rvalid_i, discard the data, no rvalid_o → IDLE. flush_i during DRAIN has no extra effect.
- A non-owner's rdata_o holds its last value; its rvalid_o stays 0.
- Watchdog:
  - Counter clears on entry to IDLE and increments in ISSUE/WAIT/DRAIN.
  - On reaching TIMEOUT_CYCLES, set timeout_o; the FSM keeps waiting.
  - The counter saturates.
- Back-to-back: after RESP→IDLE, a pending other requester is granted in IDLE, so mem_req_o reasserts 2 cycles after the previous rvalid_o.
- Fairness: with both requesters continuously requesting, grants strictly alternate.

Decomposition:
- Shared package/header (sysconfig-style defines): state encodings (3-bit), OWNER_IFU = 0 / OWNER_LSU = 1, PTE width define.
- One natural sub-module: rr_arbiter2 (combinational 2-way round-robin pick from req[1:0] and last_owner). The FSM, registers and watchdog stay in the top.

Test Plan:
- Single IFU request: ifu_req_i = 1, addr = 0x8000_1004, mem_ready_i the same cycle, mem_rvalid_i 3 cycles later with 0x2000_0C01 → mem_addr_o = 0x8000_1004; ifu_rdata_o = 0x2000_0C01 with a 1-cycle ifu_rvalid_o one cycle after mem_rvalid_i; lsu_rvalid_o stays 0.
- Simultaneous requests after reset: IFU gets the first grant, then LSU. Each requester drops req after its rvalid. mem_addr_o sequence = IFU addr then LSU addr; owner_o = 0 then 1.
- Continuous contention: both requesters hold req for 8 transactions → grants alternate IFU/LSU/IFU/..., 4 each.
- Flush in WAIT: pulse flush_i after acceptance, then mem_rvalid_i 2 cycles later → no rvalid_o to anyone; busy_o drops the cycle after mem_rvalid_i.
- Flush in ISSUE with mem_ready_i = 0 → mem_req_o deasserts next cycle and state = IDLE. Flush with mem_ready_i = 1 → DRAIN, and the response is discarded.
- Watchdog with TIMEOUT_CYCLES = 16 and mem_ready_i held 0 → timeout_o rises after 16 cycles in ISSUE and stays high after a later completion. Async rst_n low mid-WAIT → all outputs 0 immediately, state = IDLE.
